// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame sequencer: FSM states,
// RATE codes, field lengths and the RATE -> data-bits-per-symbol lookup.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    SIGNAL,
    SERVICE,
    DATA,
    TAIL,
    PAD,
    WAIT_DONE
  } state_t;

  localparam logic [3:0] RATE_R1 = 4'b1101;
  localparam logic [3:0] RATE_R2 = 4'b1111;
  localparam logic [3:0] RATE_R3 = 4'b0101;
  localparam logic [3:0] RATE_R4 = 4'b0111;
  localparam logic [3:0] RATE_R5 = 4'b1001;
  localparam logic [3:0] RATE_R6 = 4'b1011;
  localparam logic [3:0] RATE_R7 = 4'b0001;
  localparam logic [3:0] RATE_R8 = 4'b0011;

  localparam int unsigned SIG_LEN  = 24;
  localparam int unsigned SVC_LEN  = 16;
  localparam int unsigned TAIL_LEN = 6;

  // Zero marks an unsupported RATE code.
  function automatic logic [7:0] ndbps(input logic [3:0] rate);
    logic [7:0] n;
    case (rate)
      RATE_R1: n = 8'd24;
      RATE_R2: n = 8'd36;
      RATE_R3: n = 8'd48;
      RATE_R4: n = 8'd72;
      RATE_R5: n = 8'd96;
      RATE_R6: n = 8'd144;
      RATE_R7: n = 8'd192;
      RATE_R8: n = 8'd216;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tx_symbol_calc.sv
// Iterative symbol-count calculator: adds Ndbps per cycle until the frame's
// bit total (SIGNAL excluded) is covered, then reports the pad-bit count.
module tx_symbol_calc #(
  parameter int unsigned NSYM_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        ndbps_i,
  input  logic [11:0]       length_i,
  output logic              done_o,
  output logic [NSYM_W-1:0] nsym_o,
  output logic [7:0]        pads_o
);

  logic [16:0]       acc_q, acc_d;
  logic [16:0]       target;
  logic [NSYM_W-1:0] nsym_q, nsym_d;
  logic [7:0]        pads_q, pads_d;
  logic              busy_q, busy_d;

  // SERVICE (16) + PSDU (8*L) + tail (6)
  assign target = 17'd22 + {2'b00, length_i, 3'b000};
  assign done_o = busy_q && (acc_q >= target);
  assign nsym_o = nsym_q;
  assign pads_o = pads_q;

  always_comb begin
    acc_d  = acc_q;
    nsym_d = nsym_q;
    pads_d = pads_q;
    busy_d = busy_q;
    if (start_i) begin
      acc_d  = '0;
      nsym_d = '0;
      pads_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (acc_q >= target) begin
        pads_d = 8'(acc_q - target);
        busy_d = 1'b0;
      end else begin
        acc_d  = acc_q + 17'(ndbps_i);
        nsym_d = nsym_q + NSYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      nsym_q <= '0;
      pads_q <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      nsym_q <= nsym_d;
      pads_q <= pads_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Frame controller ahead of the serial transmitter: validates a request, sizes
// the frame, then streams SIGNAL, SERVICE, PSDU, tail and pad one bit per clock.
module tx_frame_sequencer
  import tx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 4095,
  parameter int unsigned NSYM_W  = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic [3:0]        Rate_In,
  input  logic [11:0]       Length_In,
  output logic              Ack,
  output logic              Err,
  output logic              Busy,
  input  logic [7:0]        Byte_Data,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              Tx_Start,
  output logic              Tx_x,
  output logic [7:0]        Num_Pads,
  output logic [NSYM_W-1:0] Nsym,
  input  logic              Tx_Done
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] len_q, len_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [7:0]  hold_q, hold_d, shift_q, shift_d;
  logic        hold_full_q, hold_full_d;
  logic [11:0] fetched_q, fetched_d;

  logic        calc_start, calc_done;
  logic        rate_ok, len_ok, byte_rdy, take, underrun, tx_bit;
  logic [7:0]  cur_byte;
  logic [23:0] sig_word;
  logic [4:0]  sig_idx;
  logic [15:0] data_last, pad_last;

  tx_symbol_calc #(.NSYM_W(NSYM_W)) u_calc (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .start_i  (calc_start),
    .ndbps_i  (ndbps(rate_q)),
    .length_i (len_q),
    .done_o   (calc_done),
    .nsym_o   (Nsym),
    .pads_o   (Num_Pads)
  );

  assign rate_ok   = (ndbps(Rate_In) != 8'd0);
  assign len_ok    = (Length_In != 12'd0) && (32'(Length_In) <= MAX_LEN);
  assign sig_word  = {rate_q, 1'b0, len_q, (^rate_q) ^ (^len_q), 6'b000000};
  assign sig_idx   = 5'(SIG_LEN - 1) - cnt_q[4:0];
  assign data_last = {1'b0, len_q, 3'b000} - 16'd1;
  assign pad_last  = {8'd0, Num_Pads} - 16'd1;

  assign byte_rdy  = (state_q inside {CALC, SIGNAL, SERVICE, DATA}) && !hold_full_q
                     && (fetched_q != len_q);
  assign take      = Byte_Valid && byte_rdy;

  assign Busy       = (state_q != IDLE);
  assign Tx_Start   = !(state_q inside {IDLE, CALC});
  assign Tx_x       = tx_bit;
  assign Ack        = ack_q;
  assign Err        = err_q;
  assign Byte_Ready = byte_rdy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rate_d      = rate_q;
    len_d       = len_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    fetched_d   = fetched_q;
    calc_start  = 1'b0;
    underrun    = 1'b0;
    tx_bit      = 1'b0;
    cur_byte    = shift_q;

    if (take) begin
      hold_d      = Byte_Data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 12'd1;
    end

    case (state_q)
      IDLE: begin
        if (Req) begin
          if (rate_ok && len_ok) begin
            rate_d      = Rate_In;
            len_d       = Length_In;
            ack_d       = 1'b1;
            fetched_d   = '0;
            hold_full_d = 1'b0;
            calc_start  = 1'b1;
            state_d     = CALC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (calc_done) begin
          cnt_d   = '0;
          state_d = SIGNAL;
        end
      end
      SIGNAL: begin
        tx_bit = sig_word[sig_idx];
        if (cnt_q == 16'(SIG_LEN - 1)) begin
          cnt_d   = '0;
          state_d = SERVICE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SERVICE: begin
        if (cnt_q == 16'(SVC_LEN - 1)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        // At a byte boundary a byte arriving this cycle bypasses the holding register.
        if (cnt_q[2:0] == 3'd0) begin
          if (hold_full_q) begin
            cur_byte    = hold_q;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (take) begin
            cur_byte    = Byte_Data;
            shift_d     = Byte_Data;
            hold_full_d = 1'b0;
          end else begin
            cur_byte = '0;
            underrun = 1'b1;
          end
        end
        tx_bit = cur_byte[cnt_q[2:0]];
        if (underrun) begin
          err_d       = 1'b1;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == data_last) begin
          cnt_d   = '0;
          state_d = TAIL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TAIL: begin
        if (cnt_q == 16'(TAIL_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (Num_Pads == 8'd0) ? WAIT_DONE : PAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PAD: begin
        if (cnt_q == pad_last) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (Tx_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rate_q      <= '0;
      len_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      fetched_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      len_q       <= len_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      fetched_q   <= fetched_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer: randomized frames and byte
// pacing checked against an arithmetic model of the frame bit stream.
module tb_tx_frame_sequencer;

  localparam int unsigned NSYM_W = 11;

  logic              Clk = 1'b0;
  logic              Reset, Req, Byte_Valid, Tx_Done;
  logic [3:0]        Rate_In;
  logic [11:0]       Length_In;
  logic [7:0]        Byte_Data;
  logic              Ack, Err, Busy, Byte_Ready, Tx_Start, Tx_x;
  logic [7:0]        Num_Pads;
  logic [NSYM_W-1:0] Nsym;

  always #5 Clk = ~Clk;

  tx_frame_sequencer #(.MAX_LEN(4095), .NSYM_W(NSYM_W)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Rate_In(Rate_In), .Length_In(Length_In),
    .Ack(Ack), .Err(Err), .Busy(Busy), .Byte_Data(Byte_Data), .Byte_Valid(Byte_Valid),
    .Byte_Ready(Byte_Ready), .Tx_Start(Tx_Start), .Tx_x(Tx_x), .Num_Pads(Num_Pads),
    .Nsym(Nsym), .Tx_Done(Tx_Done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  rate_tab[8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                               4'b1001, 4'b1011, 4'b0001, 4'b0011};
  int unsigned nd_tab[8]   = '{24, 36, 48, 72, 96, 144, 192, 216};

  logic [7:0] sup_bytes[$];
  int         sup_idx = 0;
  bit         sup_en = 1'b0;
  int         stall_run = 0;
  logic       sup_xfer;
  logic       exp_q[$];

  function automatic int unsigned model_ndbps(input logic [3:0] r);
    for (int i = 0; i < 8; i++) if (rate_tab[i] == r) return nd_tab[i];
    return 0;
  endfunction

  // Host byte source: at most two idle cycles in a row so bytes are always prompt.
  initial begin
    Byte_Valid = 1'b0;
    Byte_Data  = 8'h00;
    forever begin
      @(negedge Clk);
      sup_xfer = Byte_Valid && Byte_Ready;
      @(posedge Clk);
      #1;
      if (sup_xfer) sup_idx++;
      if (sup_en && sup_idx < sup_bytes.size() && !(stall_run < 2 && $urandom_range(0, 3) == 0)) begin
        Byte_Valid = 1'b1;
        Byte_Data  = sup_bytes[sup_idx];
        stall_run  = 0;
      end else begin
        Byte_Valid = 1'b0;
        Byte_Data  = 8'($urandom);
        if (sup_en) stall_run++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_random(input int unsigned n);
    sup_bytes.delete();
    for (int k = 0; k < int'(n); k++) sup_bytes.push_back(8'($urandom));
  endtask

  // Expected Tx_x sequence while Tx_Start is high, from the frame rules.
  task automatic build_exp(input logic [3:0] rate, input int unsigned len, input int unsigned pads);
    logic [11:0] l12;
    int nb;
    l12 = 12'(len);
    exp_q.delete();
    for (int i = 3; i >= 0; i--) exp_q.push_back(rate[i]);
    exp_q.push_back(1'b0);
    for (int i = 11; i >= 0; i--) exp_q.push_back(l12[i]);
    exp_q.push_back((^rate) ^ (^l12));
    repeat (6 + 16) exp_q.push_back(1'b0);
    nb = (sup_bytes.size() < int'(len)) ? sup_bytes.size() : int'(len);
    for (int k = 0; k < nb; k++)
      for (int b = 0; b < 8; b++) exp_q.push_back(sup_bytes[k][b]);
    repeat (6 + pads) exp_q.push_back(1'b0);
  endtask

  task automatic start_frame(input logic [3:0] rate, input int unsigned len, output int unsigned calc);
    sup_en = 1'b0;
    @(posedge Clk);
    #2;
    sup_idx = 0;
    sup_en  = 1'b1;
    @(negedge Clk);
    Req = 1'b1; Rate_In = rate; Length_In = 12'(len);
    @(negedge Clk);
    Req = 1'b0;
    n_checks++;
    if (Ack !== 1'b1 || Err !== 1'b0 || Busy !== 1'b1 || Tx_Start !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: Ack=%b Err=%b Busy=%b Tx_Start=%b, expected 1 0 1 0", Ack, Err, Busy, Tx_Start);
    end
    calc = 0;
    while (Tx_Start !== 1'b1 && calc < 3000) begin
      calc++;
      @(negedge Clk);
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input int unsigned len, input bit spam);
    int unsigned nd, tgt, nsym, pads, total, calc, nbad, first_bad, nstable, nspur, nwait, wcyc;
    nd    = model_ndbps(rate);
    tgt   = 22 + 8 * len;
    nsym  = (tgt + nd - 1) / nd;
    pads  = nsym * nd - tgt;
    total = 24 + nsym * nd;
    build_exp(rate, len, pads);
    start_frame(rate, len, calc);
    n_checks++;
    if (calc != nsym + 1) begin
      n_fail++;
      $display("FAIL calc_cycles: got %0d, expected %0d", calc, nsym + 1);
    end
    if (Tx_Start !== 1'b1) begin
      sup_en = 1'b0;
      return;
    end
    n_checks++;
    if (Nsym !== NSYM_W'(nsym)) begin
      n_fail++;
      $display("FAIL nsym: got %0d, expected %0d", Nsym, nsym);
    end
    n_checks++;
    if (Num_Pads !== 8'(pads)) begin
      n_fail++;
      $display("FAIL num_pads: got %0d, expected %0d", Num_Pads, pads);
    end
    nbad = 0; first_bad = 0; nstable = 0; nspur = 0;
    for (int unsigned i = 0; i < total; i++) begin
      if (Tx_Start !== 1'b1 || Tx_x !== exp_q[i]) begin
        if (nbad == 0) first_bad = i;
        nbad++;
      end
      if (Nsym !== NSYM_W'(nsym) || Num_Pads !== 8'(pads)) nstable++;
      if (Ack !== 1'b0 || Err !== 1'b0) nspur++;
      if (spam) begin
        Req       = ($urandom_range(0, 7) == 0);
        Rate_In   = rate_tab[$urandom_range(0, 7)];
        Length_In = 12'($urandom_range(1, 4095));
        Tx_Done   = ($urandom_range(0, 15) == 0);
      end
      @(negedge Clk);
    end
    Req = 1'b0; Tx_Done = 1'b0;
    n_checks++;
    if (nbad != 0) begin
      n_fail++;
      $display("FAIL bit_stream: %0d wrong bits, first at %0d (Tx_Start=%b Tx_x got vs expected %b)",
               nbad, first_bad, Tx_Start, exp_q[first_bad]);
    end
    n_checks++;
    if (nstable != 0 || nspur != 0) begin
      n_fail++;
      $display("FAIL frame_stability: %0d unstable Nsym/Num_Pads cycles, %0d spurious Ack/Err, expected 0 and 0",
               nstable, nspur);
    end
    nwait = 0;
    wcyc  = $urandom_range(0, 4);
    for (int unsigned w = 0; w <= wcyc; w++) begin
      if (Tx_Start !== 1'b1 || Tx_x !== 1'b0 || Busy !== 1'b1) nwait++;
      if (w == wcyc) Tx_Done = 1'b1;
      @(negedge Clk);
    end
    Tx_Done = 1'b0;
    n_checks++;
    if (nwait != 0) begin
      n_fail++;
      $display("FAIL wait_done_hold: %0d cycles without Tx_Start=1 Tx_x=0, expected 0", nwait);
    end
    n_checks++;
    if (Tx_Start !== 1'b0 || Busy !== 1'b0 || Ack !== 1'b0 || Err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: Tx_Start=%b Busy=%b Ack=%b Err=%b, expected all 0", Tx_Start, Busy, Ack, Err);
    end
    sup_en = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = 1'b0; Rate_In = '0; Length_In = '0; Tx_Done = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({Ack, Err, Busy, Byte_Ready, Tx_Start, Tx_x, Num_Pads, Nsym} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: Ack=%b Err=%b Busy=%b Rdy=%b Start=%b x=%b Pads=%0d Nsym=%0d, expected all 0",
               Ack, Err, Busy, Byte_Ready, Tx_Start, Tx_x, Num_Pads, Nsym);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || Tx_Start !== 1'b0 || Ack !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: Busy=%b Tx_Start=%b Ack=%b, expected 0 0 0", Busy, Tx_Start, Ack);
    end
  endtask

  task automatic test_invalid;
    logic [3:0] bad_rate;
    logic [3:0] rates[3];
    int unsigned lens[3];
    do bad_rate = 4'($urandom); while (model_ndbps(bad_rate) != 0);
    rates = '{4'b0000, 4'b1101, bad_rate};
    lens  = '{5, 0, $urandom_range(1, 4095)};
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      Req = 1'b1; Rate_In = rates[i]; Length_In = 12'(lens[i]);
      @(negedge Clk);
      Req = 1'b0;
      n_checks++;
      if (Err !== 1'b1 || Ack !== 1'b0 || Busy !== 1'b0 || Tx_Start !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_%0d: Err=%b Ack=%b Busy=%b Tx_Start=%b, expected 1 0 0 0", i, Err, Ack, Busy, Tx_Start);
      end
      @(negedge Clk);
      n_checks++;
      if (Err !== 1'b0 || Busy !== 1'b0 || Tx_Start !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_pulse_%0d: Err=%b Busy=%b Tx_Start=%b, expected 0 0 0", i, Err, Busy, Tx_Start);
      end
    end
  endtask

  task automatic test_underrun;
    int unsigned calc, n, nbad;
    fill_random(2);
    build_exp(4'b1101, 4, 0);
    start_frame(4'b1101, 4, calc);
    n = 0; nbad = 0;
    while (Tx_Start === 1'b1 && n < 300) begin
      if (n < 56 && Tx_x !== exp_q[n]) nbad++;
      n++;
      @(negedge Clk);
    end
    n_checks++;
    if (n != 57 || nbad != 0) begin
      n_fail++;
      $display("FAIL underrun_drop: Tx_Start high for %0d cycles with %0d bad bits, expected 57 and 0", n, nbad);
    end
    n_checks++;
    if (Err !== 1'b1 || Busy !== 1'b0 || Byte_Ready !== 1'b0 || Ack !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_flags: Err=%b Busy=%b Byte_Ready=%b Ack=%b, expected 1 0 0 0", Err, Busy, Byte_Ready, Ack);
    end
    @(negedge Clk);
    n_checks++;
    if (Err !== 1'b0 || Byte_Ready !== 1'b0 || Tx_Start !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_idle: Err=%b Byte_Ready=%b Tx_Start=%b, expected 0 0 0", Err, Byte_Ready, Tx_Start);
    end
    sup_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int unsigned calc;
    fill_random(20);
    start_frame(4'b1001, 20, calc);
    repeat (45) @(negedge Clk);
    n_checks++;
    if (Tx_Start !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_active: Tx_Start=%b Busy=%b, expected 1 1", Tx_Start, Busy);
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({Ack, Err, Busy, Byte_Ready, Tx_Start, Tx_x, Num_Pads, Nsym} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: Ack=%b Err=%b Busy=%b Rdy=%b Start=%b x=%b Pads=%0d Nsym=%0d, expected all 0",
               Ack, Err, Busy, Byte_Ready, Tx_Start, Tx_x, Num_Pads, Nsym);
    end
    sup_en = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    fill_random(30);
    run_frame(rate_tab[$urandom_range(0, 7)], 30, 1'b0);
  endtask

  task automatic test_basic_frames;
    fill_random(100);
    run_frame(4'b1101, 100, 1'b0);
    sup_bytes.delete();
    sup_bytes.push_back(8'hA5);
    run_frame(4'b0011, 1, 1'b0);
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 4; i++) begin
      int unsigned len;
      len = $urandom_range(1, 200);
      fill_random(len);
      run_frame(rate_tab[$urandom_range(0, 7)], len, 1'b1);
    end
  endtask

  task automatic test_max_len;
    fill_random(4095);
    run_frame(4'b1101, 4095, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_invalid();
    test_underrun();
    test_reset_mid_frame();
    test_random_frames();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
